// File: rtl/fetch_stage.sv
// Fetch stage: a four-state sequencer (IDLE/REQ/HOLD/HALT) that reads one
// 16-bit instruction at a time from instruction memory. It holds each
// instruction for downstream until it is accepted, and it honours
// branch/jump redirects from execute.
module fetch_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redir_valid,
    input  logic [15:0] redir_pc,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ready,
    input  logic [15:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [15:0] instr,
    output logic [15:0] instr_pc,
    output logic [15:0] PC_old,
    output logic        halted,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, REQ, HOLD, HALT} state_t;

    state_t      state_q;
    logic [15:0] pc_q;
    logic [15:0] instr_q;
    logic [15:0] instr_pc_q;
    logic [15:0] pc_old_q;
    logic        err_q;

    // The outputs are decoded only from registers, so no input reaches an
    // output combinationally.
    assign imem_req    = (state_q == REQ);
    assign imem_addr   = pc_q;
    assign instr_valid = (state_q == HOLD);
    assign halted      = (state_q == HALT);
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign PC_old      = pc_old_q;
    assign err         = err_q;

    // Sequencer. A redirect outranks every other transition and squashes any
    // concurrent memory data or downstream accept. HALT exits only on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= 16'h0000;
            instr_q    <= 16'h0000;
            instr_pc_q <= 16'h0000;
            pc_old_q   <= 16'h0002;
            err_q      <= 1'b0;
        end else if (state_q != HALT && redir_valid) begin
            if (redir_pc[0]) begin
                err_q   <= 1'b1;
                state_q <= HALT;
            end else begin
                pc_q    <= redir_pc;
                state_q <= REQ;
            end
        end else begin
            case (state_q)
                IDLE: state_q <= REQ;
                REQ: begin
                    if (imem_ready) begin
                        instr_q    <= imem_rdata;
                        instr_pc_q <= pc_q;
                        pc_old_q   <= pc_q + 16'd2;
                        state_q    <= HOLD;
                    end
                end
                HOLD: begin
                    if (instr_ready) begin
                        pc_q    <= pc_q + 16'd2;
                        state_q <= (instr_q[15:11] == 5'b00000) ? HALT : REQ;
                    end
                end
                default: state_q <= HALT;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus a random run. Each cycle the
// DUT is compared against a transaction-level model of the fetch stage.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redir_valid = 1'b0;
    logic [15:0] redir_pc = 16'h0000;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [15:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic [15:0] PC_old;
    logic        halted;
    logic        err;

    logic [15:0] halt_addr = 16'h0001;  // odd address: never fetched
    int          n_chk = 0;
    int          n_err = 0;

    // Model state: the PC, whether an instruction is waiting downstream, and
    // the sticky stop/error flags.
    logic [15:0] m_pc, m_instr, m_ipc;
    bit          m_started, m_have, m_halted, m_err;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk(clk), .rst_n(rst_n), .redir_valid(redir_valid), .redir_pc(redir_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rdata(imem_rdata), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc), .PC_old(PC_old), .halted(halted), .err(err)
    );

    function automatic logic [15:0] memf(input logic [15:0] a, input logic [15:0] h);
        logic [15:0] t;
        t = a * 16'h9E37;
        if (a == h) return 16'h0000;
        return (t ^ 16'h5A5A) | 16'h0800;
    endfunction

    assign imem_rdata = imem_ready ? memf(imem_addr, halt_addr) : 16'hDEAD;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_pc = 16'h0000; m_instr = 16'h0000; m_ipc = 16'h0000;
        m_started = 0; m_have = 0; m_halted = 0; m_err = 0;
    endtask

    task automatic m_update();
        if (!rst_n || m_halted) return;
        if (redir_valid) begin
            if (redir_pc[0]) begin m_err = 1; m_halted = 1; end
            else begin m_pc = redir_pc; m_have = 0; m_started = 1; end
        end else if (!m_started) begin
            m_started = 1;
        end else if (m_have) begin
            if (instr_ready) begin
                m_pc = m_pc + 16'd2;
                m_have = 0;
                if (m_instr[15:11] == 5'd0) m_halted = 1;
            end
        end else if (imem_ready) begin
            m_instr = memf(m_pc, halt_addr);
            m_ipc = m_pc;
            m_have = 1;
        end
    endtask

    // Compare every output on the falling edge, then advance the model on the
    // rising edge with the inputs the DUT saw.
    task automatic step();
        @(negedge clk);
        chk("imem_req",    {31'd0, imem_req},    {31'd0, m_started && !m_have && !m_halted});
        chk("imem_addr",   {16'd0, imem_addr},   {16'd0, m_pc});
        chk("instr_valid", {31'd0, instr_valid}, {31'd0, m_have && !m_halted});
        chk("instr",       {16'd0, instr},       {16'd0, m_instr});
        chk("instr_pc",    {16'd0, instr_pc},    {16'd0, m_ipc});
        chk("PC_old",      {16'd0, PC_old},      {16'd0, m_ipc + 16'd2});
        chk("halted",      {31'd0, halted},      {31'd0, m_halted});
        chk("err",         {31'd0, err},         {31'd0, m_err});
        @(posedge clk);
        m_update();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; redir_valid = 1'b0; imem_ready = 1'b0; instr_ready = 1'b0;
        m_reset();
        step(); step();
        rst_n = 1'b1;
    endtask

    // Run until the model holds an instruction; an expired bound counts as a failure.
    task automatic wait_have();
        int k = 0;
        imem_ready = 1'b1; instr_ready = 1'b0;
        while (!m_have && k < 20) begin step(); k++; end
        chk("wait_have_timeout", {31'd0, m_have}, 32'd1);
    endtask

    initial begin
        m_reset();
        #1;
        // Reset values and straight-line fetch with everything ready
        do_reset();
        imem_ready = 1'b1; instr_ready = 1'b1;
        step();
        chk("first_addr", {16'd0, imem_addr}, 32'h0000);
        repeat (8) step();

        // Memory stall for 3 cycles, then downstream stall for 5 cycles
        do_reset();
        imem_ready = 1'b0; instr_ready = 1'b0;
        repeat (4) step();
        imem_ready = 1'b1; step();
        imem_ready = 1'b0;
        repeat (5) step();
        chk("hold_valid", {31'd0, instr_valid}, 32'd1);
        instr_ready = 1'b1; repeat (4) step();

        // Redirect in the same cycle as a downstream accept
        wait_have();
        redir_valid = 1'b1; redir_pc = 16'h0040; instr_ready = 1'b1;
        step();
        redir_valid = 1'b0; imem_ready = 1'b0;
        step();
        chk("redir_addr", {16'd0, imem_addr}, 32'h0040);

        // A misaligned redirect halts with err; later redirects are ignored
        redir_valid = 1'b1; redir_pc = 16'h0041; step();
        redir_pc = 16'h0080; step(); step();
        redir_valid = 1'b0;
        chk("mis_err", {31'd0, err}, 32'd1);
        chk("mis_halt", {31'd0, halted}, 32'd1);

        // Fetching and accepting the all-zero word halts the stage
        do_reset();
        halt_addr = 16'h0012;
        redir_valid = 1'b1; redir_pc = 16'h0010; step();
        redir_valid = 1'b0; imem_ready = 1'b1; instr_ready = 1'b1;
        repeat (8) step();
        chk("halt_word", {31'd0, halted}, 32'd1);
        halt_addr = 16'h0001;

        // The PC wraps from 0xFFFE to 0x0000
        do_reset();
        redir_valid = 1'b1; redir_pc = 16'hFFFE; step();
        redir_valid = 1'b0;
        wait_have();
        instr_ready = 1'b1; imem_ready = 1'b0; step();
        chk("wrap_addr", {16'd0, imem_addr}, 32'h0000);

        // Random traffic, including occasional resets and halt words
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                halt_addr = ($urandom_range(0, 3) == 0) ? {$urandom_range(0, 63), 1'b0} : 16'h0001;
                do_reset();
            end
            redir_valid = ($urandom_range(0, 15) == 0);
            redir_pc    = $urandom_range(0, 65535);
            if ($urandom_range(0, 7) != 0) redir_pc[0] = 1'b0;
            imem_ready  = $urandom_range(0, 2) != 0;
            instr_ready = $urandom_range(0, 2) != 0;
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
